// File: rtl/multdiv_stall_unit.sv
// Decode/execute interlock: load-use stalls and mul/div sequencing (IDLE/BUSY/DONE).
// Optional BUSY watchdog enabled by defining MULTDIV_TIMEOUT_EN.
module multdiv_stall_unit #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] FD_Latch_Instr,
  input  logic [31:0] DX_Latch_Instr,
  input  logic        flush,
  input  logic        data_resultRDY,
  input  logic        data_exception,
  input  logic [31:0] data_result,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        PC_stall,
  output logic        FD_stall,
  output logic        DX_stall,
  output logic        DX_bubble,
  output logic        XM_bubble,
  output logic [31:0] md_result,
  output logic        md_result_valid,
  output logic        md_error,
  output logic [7:0]  md_cycles
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_rd, dx_alu;
  assign fd_op  = FD_Latch_Instr[31:27];
  assign fd_rd  = FD_Latch_Instr[26:22];
  assign fd_rs  = FD_Latch_Instr[21:17];
  assign fd_rt  = FD_Latch_Instr[16:12];
  assign dx_op  = DX_Latch_Instr[31:27];
  assign dx_rd  = DX_Latch_Instr[26:22];
  assign dx_alu = DX_Latch_Instr[6:2];

  logic unused_instr_bits;
  assign unused_instr_bits = ^{FD_Latch_Instr[11:0], DX_Latch_Instr[21:7], DX_Latch_Instr[1:0]};

  logic dx_mul, dx_div;
  assign dx_mul = (dx_op == 5'd0) && (dx_alu == 5'd6);
  assign dx_div = (dx_op == 5'd0) && (dx_alu == 5'd7);

  // Which FD fields are read as sources depends on the FD opcode.
  logic hit_rs, hit_rt, hit_rd, load_use;
  assign hit_rs = (fd_rs == dx_rd);
  assign hit_rt = (fd_rt == dx_rd);
  assign hit_rd = (fd_rd == dx_rd);

  always_comb begin
    load_use = 1'b0;
    if (dx_op == 5'd8 && dx_rd != 5'd0) begin
      case (fd_op)
        5'd0:       load_use = hit_rs | hit_rt;
        5'd5, 5'd8: load_use = hit_rs;
        5'd7:       load_use = hit_rs | hit_rd;
        5'd2, 5'd6: load_use = hit_rd | hit_rs;
        5'd4:       load_use = hit_rd;
        default:    load_use = 1'b0;
      endcase
    end
  end

  logic idle_go, start, lu_stall, busy;
  assign idle_go  = !reset && (state == IDLE) && !flush;
  assign start    = idle_go && (dx_mul || dx_div);
  assign lu_stall = idle_go && load_use;
  assign busy     = (state == BUSY);

  assign ctrl_MULT = start && dx_mul;
  assign ctrl_DIV  = start && dx_div;
  assign PC_stall  = busy | start | lu_stall;
  assign FD_stall  = busy | start | lu_stall;
  assign DX_stall  = busy | start;
  assign DX_bubble = lu_stall;
  assign XM_bubble = busy | start;

  logic timeout_hit;
`ifdef MULTDIV_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  assign timeout_hit = busy && (md_cycles == TO_LAST) && !data_resultRDY;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      md_result       <= '0;
      md_error        <= 1'b0;
      md_result_valid <= 1'b0;
      md_cycles       <= '0;
    end else begin
      case (state)
        IDLE: begin
          md_result_valid <= 1'b0;
          if (start) begin
            state     <= BUSY;
            md_cycles <= '0;
          end
        end
        BUSY: begin
          if (md_cycles != 8'hff) md_cycles <= md_cycles + 8'd1;
          if (data_resultRDY) begin
            md_result       <= data_result;
            md_error        <= data_exception;
            md_result_valid <= 1'b1;
            state           <= DONE;
          end else if (timeout_hit) begin
            md_result       <= '0;
            md_error        <= 1'b1;
            md_result_valid <= 1'b1;
            state           <= DONE;
          end
        end
        DONE: begin
          // Start is deliberately not evaluated here; DX advances on this edge.
          md_result_valid <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_stall_unit.sv
// Bench for multdiv_stall_unit: directed scenarios then random traffic against a
// cycle-level behavioural model of the interlock rules.
module tb_multdiv_stall_unit;
`ifdef MULTDIV_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic        clock, reset, flush, data_resultRDY, data_exception;
  logic [31:0] FD_Latch_Instr, DX_Latch_Instr, data_result;
  logic        ctrl_MULT, ctrl_DIV, PC_stall, FD_stall, DX_stall, DX_bubble, XM_bubble;
  logic [31:0] md_result;
  logic        md_result_valid, md_error;
  logic [7:0]  md_cycles;

  multdiv_stall_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .FD_Latch_Instr(FD_Latch_Instr), .DX_Latch_Instr(DX_Latch_Instr),
    .flush(flush), .data_resultRDY(data_resultRDY), .data_exception(data_exception),
    .data_result(data_result), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .PC_stall(PC_stall), .FD_stall(FD_stall), .DX_stall(DX_stall),
    .DX_bubble(DX_bubble), .XM_bubble(XM_bubble), .md_result(md_result),
    .md_result_valid(md_result_valid), .md_error(md_error), .md_cycles(md_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Model: 0 = free, 1 = waiting on multdiv, 2 = presenting result.
  int          m_phase;
  int          m_waited;
  logic [31:0] m_res;
  logic        m_err;

  function automatic logic [31:0] ins(int op, int rd, int rs, int rt, int alu);
    logic [31:0] w;
    w = '0;
    w[31:27] = op[4:0]; w[26:22] = rd[4:0]; w[21:17] = rs[4:0];
    w[16:12] = rt[4:0]; w[6:2] = alu[4:0];
    return w;
  endfunction

  function automatic bit is_mul(logic [31:0] i);
    return i[31:27] == 0 && i[6:2] == 6;
  endfunction
  function automatic bit is_div(logic [31:0] i);
    return i[31:27] == 0 && i[6:2] == 7;
  endfunction

  // Source registers an FD instruction reads, as a list.
  function automatic bit hazard(logic [31:0] fd, logic [31:0] dx);
    int srcs[$];
    int op, rd, rs, rt, dst;
    op = fd[31:27]; rd = fd[26:22]; rs = fd[21:17]; rt = fd[16:12];
    dst = dx[26:22];
    if (dx[31:27] != 8 || dst == 0) return 0;
    if (op == 0)                srcs = '{rs, rt};
    else if (op == 5 || op == 8) srcs = '{rs};
    else if (op == 7)           srcs = '{rs, rd};
    else if (op == 2 || op == 6) srcs = '{rd, rs};
    else if (op == 4)           srcs = '{rd};
    foreach (srcs[k]) if (srcs[k] == dst) return 1;
    return 0;
  endfunction

  task automatic model_clear();
    m_phase = 0; m_waited = 0; m_res = '0; m_err = 1'b0;
  endtask

  task automatic check_now(string tag);
    bit free, st, lu, bz;
    logic [8:0] obs, exp;
    if (reset) model_clear();
    free = !reset && m_phase == 0 && !flush;
    st   = free && (is_mul(DX_Latch_Instr) || is_div(DX_Latch_Instr));
    lu   = free && hazard(FD_Latch_Instr, DX_Latch_Instr);
    bz   = m_phase == 1;
    exp  = {st && is_mul(DX_Latch_Instr), st && is_div(DX_Latch_Instr),
            bz || st || lu, bz || st || lu, bz || st, lu, bz || st,
            m_phase == 2, m_err};
    obs  = {ctrl_MULT, ctrl_DIV, PC_stall, FD_stall, DX_stall, DX_bubble,
            XM_bubble, md_result_valid, md_error};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s ctl obs=%b exp=%b", tag, obs, exp);
    end
    tests++;
    assert (md_result === m_res) else begin
      fails++;
      $error("FAIL %s md_result obs=%h exp=%h", tag, md_result, m_res);
    end
    tests++;
    assert (md_cycles === 8'(m_waited)) else begin
      fails++;
      $error("FAIL %s md_cycles obs=%0d exp=%0d", tag, md_cycles, m_waited);
    end
  endtask

  task automatic tick(string tag);
    bit st;
    @(negedge clock);
    check_now(tag);
    @(posedge clock);
    if (reset) model_clear();
    else if (m_phase == 0) begin
      st = !flush && (is_mul(DX_Latch_Instr) || is_div(DX_Latch_Instr));
      if (st) begin m_phase = 1; m_waited = 0; end
    end else if (m_phase == 1) begin
      bit expire;
      expire = 0;
`ifdef MULTDIV_TIMEOUT_EN
      expire = (m_waited == TO - 1);
`endif
      if (data_resultRDY) begin
        m_res = data_result; m_err = data_exception; m_phase = 2;
      end else if (expire) begin
        m_res = '0; m_err = 1'b1; m_phase = 2;
      end
      if (m_waited < 255) m_waited++;
    end else m_phase = 0;
    #1;
  endtask

  task automatic set_in(logic [31:0] fd, logic [31:0] dx, logic fl, logic rdy,
                        logic ex, logic [31:0] res);
    FD_Latch_Instr = fd; DX_Latch_Instr = dx; flush = fl;
    data_resultRDY = rdy; data_exception = ex; data_result = res;
  endtask

  function automatic logic [31:0] rnd_fd();
    int ops[8] = '{0, 2, 4, 5, 6, 7, 8, 3};
    return ins(ops[$urandom_range(0, 7)], $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rnd_dx();
    case ($urandom_range(0, 5))
      0: return ins(8, $urandom_range(0, 7), $urandom_range(0, 7), 0, 0);
      1: return ins(0, $urandom_range(1, 7), 1, 2, 6);
      2: return ins(0, $urandom_range(1, 7), 1, 2, 7);
      3: return ins(0, $urandom_range(1, 7), 1, 2, 0);
      4: return '0;
      default: return $urandom;
    endcase
  endfunction

  localparam logic [31:0] NOP = 32'h0;

  initial begin
    logic [31:0] mul_i, div_i, lw5;
    model_clear();
    mul_i = ins(0, 3, 1, 2, 6);
    div_i = ins(0, 4, 1, 2, 7);
    lw5   = ins(8, 5, 1, 0, 0);

    reset = 1'b1;
    set_in(NOP, NOP, 0, 0, 0, 0);
    tick("reset");
    tick("reset2");
    reset = 1'b0;
    tick("idle");

    // Load-use: add r6,r5,r2 behind lw r5 stalls once; rt=r7 form does not.
    set_in(ins(0, 6, 5, 2, 0), lw5, 0, 0, 0, 0);
    tick("lu_hit");
    set_in(ins(0, 6, 5, 2, 0), NOP, 0, 0, 0, 0);
    tick("lu_after");
    set_in(ins(0, 6, 2, 7, 0), lw5, 0, 0, 0, 0);
    tick("lu_miss");
    set_in(ins(4, 5, 0, 0, 0), lw5, 0, 0, 0, 0);
    tick("lu_op4");
    set_in(ins(0, 0, 0, 0, 0), ins(8, 0, 1, 0, 0), 0, 0, 0, 0);
    tick("lu_r0");

    // mul, result after 17 BUSY cycles; also an RDY in the start cycle is ignored.
    set_in(NOP, mul_i, 0, 1, 0, 32'hdead);
    tick("mul_start");
    data_resultRDY = 0;
    for (int i = 0; i < 16; i++) tick("mul_busy");
    set_in(NOP, mul_i, 0, 1, 0, 32'h0000_0f00);
    tick("mul_rdy");
    set_in(NOP, NOP, 0, 0, 0, 0);
    tick("mul_done");
    tick("mul_idle");

    // div with exception, then mul without clears md_error.
    set_in(NOP, div_i, 0, 0, 0, 0);
    tick("div_start");
    for (int i = 0; i < 3; i++) tick("div_busy");
    set_in(NOP, div_i, 0, 1, 1, 32'h1234);
    tick("div_rdy");
    set_in(NOP, NOP, 0, 0, 0, 0);
    tick("div_done");
    set_in(NOP, mul_i, 0, 0, 0, 0);
    tick("mul2_start");
    set_in(NOP, mul_i, 0, 1, 0, 32'h55);
    tick("mul2_rdy");
    // Back-to-back: div arrives in DX as the mul leaves in DONE.
    set_in(div_i, mul_i, 0, 0, 0, 0);
    tick("b2b_done");
    set_in(NOP, div_i, 0, 0, 0, 0);
    tick("b2b_div_start");
    set_in(NOP, div_i, 0, 1, 0, 32'h77);
    tick("b2b_div_rdy");
    set_in(NOP, NOP, 0, 0, 0, 0);
    tick("b2b_div_done");

    // flush suppresses both stalls and starts.
    set_in(ins(0, 6, 5, 2, 0), lw5, 1, 0, 0, 0);
    tick("flush_lu");
    set_in(NOP, mul_i, 1, 0, 0, 0);
    tick("flush_mul");

    // Reset mid-BUSY (cycle 5) clears everything immediately.
    set_in(NOP, mul_i, 0, 0, 0, 0);
    tick("rst_start");
    for (int i = 0; i < 4; i++) tick("rst_busy");
    reset = 1'b1;
    #1;
    check_now("rst_async");
    tick("rst_held");
    reset = 1'b0;
    set_in(NOP, NOP, 0, 0, 0, 0);
    tick("rst_release");

    // Long wait: timeout build aborts, default build saturates md_cycles.
    set_in(NOP, mul_i, 0, 0, 0, 0);
    tick("long_start");
    set_in(NOP, NOP, 0, 0, 0, 0);
    for (int i = 0; i < 270; i++) tick("long_wait");
    set_in(NOP, NOP, 0, 1, 0, 32'habc);
    tick("long_rdy");
    set_in(NOP, NOP, 0, 0, 0, 0);
    tick("long_done");
    tick("long_idle");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      set_in(rnd_fd(), rnd_dx(), $urandom_range(0, 7) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 1), $urandom);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
